fb_access_arbiter: RTL and testbench
====================================

// Module: fb_access_arbiter
// PURPOSE
// - Sole owner of the 80x60 character frame-buffer RAM port (4800 entries, addr 0..0x12BF).
// - Shares that port between the display address generator (read-only, deadline-bound) and a host port (read/write).
// - Also runs a hardware clear sequencer that fills the whole buffer with a constant.
// - Sits between the display plane / pixel FIFO path and the frame-buffer RAM.
// PARAMETERS
// - DEPTH         4800  number of frame-buffer entries; valid addresses 0..DEPTH-1
// - AW            13    address width
// - DW            8     data width (character code)
// - MEM_LAT       1     RAM read latency in clk cycles, from mem_en to mem_rdata valid
// - HOST_MAX_WAIT 8     consecutive denied host-request cycles before the host is forced a grant
// PORTS
// - clk          in   1   clock; all state updates on the falling edge
// - rst          in   1   asynchronous reset, active-low
// - disp_req     in   1   display read request
// - disp_addr    in   AW  display read address
// - disp_gnt     out  1   display request accepted this cycle
// - disp_rvalid  out  1   disp_rdata valid
// - disp_rdata   out  DW  display read data
// - host_req     in   1   host request; held until host_gnt
// - host_we      in   1   1 = write, 0 = read
// - host_addr    in   AW  host address
// - host_wdata   in   DW  host write data
// - host_gnt     out  1   host request accepted this cycle
// - host_rvalid  out  1   host_rdata valid
// - host_rdata   out  DW  host read data
// - clr_start    in   1   pulse: start clear of entire buffer
// - clr_value    in   DW  fill value, sampled on accepted clr_start
// - clr_busy     out  1   clear in progress
// - clr_done     out  1   one-cycle pulse after last clear write issued
// - mem_en       out  1   RAM access strobe (registered)
// - mem_we       out  1   RAM write enable (registered)
// - mem_addr     out  AW  RAM address (registered)
// - mem_wdata    out  DW  RAM write data (registered)
// - mem_rdata    in   DW  RAM read data
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, wait counter 0, clear pointer 0, read tag pipe empty.
//   Reset mid-clear aborts the clear; no clr_done is emitted.
// - Arbitration is combinational per cycle; at most one gnt per cycle. Winner's command is registered onto mem_* at the next edge.
// - Priority, highest first:
//   1. host, when wait_cnt == HOST_MAX_WAIT
//   2. display
//   3. clear write (state CLEAR)
//   4. host (IDLE only; host blocked in CLEAR except via rule 1)
// - wait_cnt increments each cycle host_req=1 and host_gnt=0, saturating at HOST_MAX_WAIT.
//   It clears to 0 on host_gnt or when host_req=0.
// - Reads: gnt-to-rvalid latency is 1+MEM_LAT cycles; rvalid is one cycle wide.
//   Requester tag travels in a MEM_LAT-deep pipe so rdata is steered to the correct port; writes carry no tag.
// - disp_rdata/host_rdata hold their last value when the matching rvalid=0.
// - FSM IDLE -> CLEAR on clr_start in IDLE; clr_value latched, ptr=0, clr_busy=1 the next cycle.
// - CLEAR: each cycle with no higher-priority winner issues write(ptr, clr_value) and ptr++.
//   When write at ptr==DEPTH-1 is issued: ptr=0, -> IDLE, clr_done pulses the following cycle.
// - clr_start while in CLEAR is ignored.
// - Host write and clear both target an address: the later-issued write wins (no merging).
// - Idle cycle (no winner): mem_en=0; mem_we=0; mem_addr/mem_wdata hold.
// CONFIGURATION
// - FB_ADDR_CHECK_EN defined: a host request with host_addr >= DEPTH is granted but issues no RAM access.
//   - Read: host_rvalid after 1+MEM_LAT cycles with host_rdata=0.
//   - Write: dropped.
//   - Display addresses >= DEPTH are also dropped: disp_gnt=1, disp_rvalid, disp_rdata=0.
// - FB_ADDR_CHECK_EN undefined: addresses are passed to mem_addr unchecked.
// TESTING
// - Reset: rst=0 mid-clear at ptr=100 -> all outputs 0, clr_busy=0, no clr_done after rst=1.
// - Simultaneous disp_req and host_req(read, 0x0010), wait_cnt=0 -> disp_gnt=1, host_gnt=0; the host is granted the first free cycle.
// - disp_req held high 20 cycles with host write 0x12BF=0x41 -> host_gnt on cycle 9 (after 8 denied); mem write seen next edge.
// - clr_start, clr_value=0x20, no other requests -> 4800 writes at addr 0..0x12BF.
//   clr_busy high 4800 cycles; clr_done one pulse; a host read of 0x0000 afterwards returns 0x20.
// - MEM_LAT=2: alternating disp read 0x0001 / host read 0x0002 -> each rvalid fires 3 cycles after its gnt, with the correct data on the correct port.
// - FB_ADDR_CHECK_EN: host write 0x12C0 -> host_gnt=1, mem_en stays 0; host read 0x1FFF -> host_rvalid with host_rdata=0.

Source files
------------

// File: rtl/fb_access_arbiter.sv
// Frame-buffer RAM port arbiter: display reads, host reads/writes and a hardware clear sequencer.
// Optional macro FB_ADDR_CHECK_EN: out-of-range addresses are granted but never reach the RAM.
module fb_access_arbiter #(
  parameter int DEPTH         = 4800,
  parameter int AW            = 13,
  parameter int DW            = 8,
  parameter int MEM_LAT       = 1,
  parameter int HOST_MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_gnt,
  output logic          disp_rvalid,
  output logic [DW-1:0] disp_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  input  logic          clr_start,
  input  logic [DW-1:0] clr_value,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int WCW = $clog2(HOST_MAX_WAIT + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_HOST} tag_t;

  state_t          state, state_next;
  logic [WCW-1:0]  wait_cnt;
  logic [AW-1:0]   clr_ptr;
  logic [DW-1:0]   clr_val;
  logic            host_force, clr_win, disp_ok, host_ok;
  logic            issue_en, issue_we, issue_zero;
  logic [AW-1:0]   issue_addr;
  logic [DW-1:0]   issue_wdata;
  tag_t            issue_tag;
  tag_t            tag_pipe  [MEM_LAT+1];
  logic            zero_pipe [MEM_LAT+1];
  logic [DW-1:0]   ret_data, disp_hold, host_hold;

`ifdef FB_ADDR_CHECK_EN
  assign disp_ok = (disp_addr <= LAST_ADDR);
  assign host_ok = (host_addr <= LAST_ADDR);
`else
  assign disp_ok = 1'b1;
  assign host_ok = 1'b1;
`endif

  assign host_force = host_req && (wait_cnt == WCW'(HOST_MAX_WAIT));
  assign clr_busy   = (state == CLEAR);

  always_comb begin
    state_next  = state;
    disp_gnt    = 1'b0;
    host_gnt    = 1'b0;
    clr_win     = 1'b0;
    issue_en    = 1'b0;
    issue_we    = 1'b0;
    issue_addr  = '0;
    issue_wdata = '0;
    issue_tag   = TAG_NONE;
    issue_zero  = 1'b0;

    if (host_force)          host_gnt = 1'b1;
    else if (disp_req)       disp_gnt = 1'b1;
    else if (state == CLEAR) clr_win  = 1'b1;
    else if (host_req)       host_gnt = 1'b1;

    // Dropped (out-of-range) reads still travel the tag pipe so the requester sees rvalid with zero data
    if (host_gnt) begin
      issue_en    = host_ok;
      issue_we    = host_we;
      issue_addr  = host_addr;
      issue_wdata = host_wdata;
      issue_tag   = host_we ? TAG_NONE : TAG_HOST;
      issue_zero  = !host_ok;
    end else if (disp_gnt) begin
      issue_en   = disp_ok;
      issue_addr = disp_addr;
      issue_tag  = TAG_DISP;
      issue_zero = !disp_ok;
    end else if (clr_win) begin
      issue_en    = 1'b1;
      issue_we    = 1'b1;
      issue_addr  = clr_ptr;
      issue_wdata = clr_val;
    end

    case (state)
      IDLE:    if (clr_start) state_next = CLEAR;
      CLEAR:   if (clr_win && clr_ptr == LAST_ADDR) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      clr_ptr  <= '0;
      clr_val  <= '0;
      clr_done <= 1'b0;
    end else begin
      if (host_req && !host_gnt) begin
        if (wait_cnt != WCW'(HOST_MAX_WAIT)) wait_cnt <= wait_cnt + WCW'(1);
      end else begin
        wait_cnt <= '0;
      end
      if (state == IDLE && clr_start) begin
        clr_ptr <= '0;
        clr_val <= clr_value;
      end else if (clr_win) begin
        clr_ptr <= (clr_ptr == LAST_ADDR) ? '0 : clr_ptr + AW'(1);
      end
      clr_done <= clr_win && (clr_ptr == LAST_ADDR);
    end
  end

  // Address and data hold on idle cycles; only the strobes drop
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= issue_en;
      mem_we <= issue_en && issue_we;
      if (issue_en)             mem_addr  <= issue_addr;
      if (issue_en && issue_we) mem_wdata <= issue_wdata;
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i <= MEM_LAT; i++) begin
        tag_pipe[i]  <= TAG_NONE;
        zero_pipe[i] <= 1'b0;
      end
      disp_hold <= '0;
      host_hold <= '0;
    end else begin
      tag_pipe[0]  <= issue_tag;
      zero_pipe[0] <= issue_zero;
      for (int i = 1; i <= MEM_LAT; i++) begin
        tag_pipe[i]  <= tag_pipe[i-1];
        zero_pipe[i] <= zero_pipe[i-1];
      end
      if (disp_rvalid) disp_hold <= ret_data;
      if (host_rvalid) host_hold <= ret_data;
    end
  end

  assign disp_rvalid = (tag_pipe[MEM_LAT] == TAG_DISP);
  assign host_rvalid = (tag_pipe[MEM_LAT] == TAG_HOST);
  assign ret_data    = zero_pipe[MEM_LAT] ? '0 : mem_rdata;
  assign disp_rdata  = disp_rvalid ? ret_data : disp_hold;
  assign host_rdata  = host_rvalid ? ret_data : host_hold;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Randomised bench for fb_access_arbiter against a cycle-level behavioural model and a RAM model.
// Directed phases cover reset mid-clear, display/host contention, host starvation, full clear and two-deep read latency.
module tb_fb_access_arbiter;

  localparam int DEPTH = 4800;
  localparam int AW    = 13;
  localparam int DW    = 8;
  localparam int LAT   = 2;
  localparam int HMW   = 8;

  logic          clk = 1'b1;
  logic          rst = 1'b0;
  logic          disp_req = 1'b0, host_req = 1'b0, host_we = 1'b0, clr_start = 1'b0;
  logic [AW-1:0] disp_addr = '0, host_addr = '0;
  logic [DW-1:0] host_wdata = '0, clr_value = '0;
  logic          disp_gnt, disp_rvalid, host_gnt, host_rvalid, clr_busy, clr_done;
  logic          mem_en, mem_we;
  logic [DW-1:0] disp_rdata, host_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  fb_access_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .MEM_LAT(LAT), .HOST_MAX_WAIT(HMW)) dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .clr_start(clr_start), .clr_value(clr_value), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM with LAT cycles from a sampled mem_en to valid mem_rdata
  logic [DW-1:0] ram      [8192];
  logic [DW-1:0] ram_pipe [LAT];
  assign mem_rdata = ram_pipe[LAT-1];

  always @(negedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    ram_pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr] : 8'h00;
    for (int i = 1; i < LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
  end

  typedef struct {
    int            due;
    bit            is_host;
    logic [DW-1:0] data;
  } ret_t;

  int            n_compared = 0;
  int            n_mismatched = 0;
  int            cyc = 0;
  int            m_wait, m_ptr, m_exp_addr;
  bit            m_clearing, m_done_due, m_exp_en, m_exp_we;
  logic [DW-1:0] m_cval, m_exp_wdata, m_disp_last, m_host_last;
  logic [DW-1:0] m_mem [8192];
  ret_t          m_rets [$];
  logic          last_dgnt, last_hgnt, last_busy, last_done, last_hrv, last_drv;
  logic [DW-1:0] last_hrd, last_drd;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_compared++;
    if (got !== want) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic bit in_range(input logic [AW-1:0] a);
`ifdef FB_ADDR_CHECK_EN
    return int'(a) < DEPTH;
`else
    return 1'b1;
`endif
  endfunction

  task automatic modelReset();
    m_wait = 0; m_ptr = 0; m_clearing = 0; m_done_due = 0;
    m_exp_en = 0; m_exp_we = 0; m_exp_addr = 0; m_exp_wdata = '0;
    m_disp_last = '0; m_host_last = '0;
    m_rets.delete();
  endtask

  task automatic pushRead(input bit is_host, input logic [AW-1:0] a);
    ret_t r;
    r.due = cyc + 1 + LAT;
    r.is_host = is_host;
    r.data = in_range(a) ? m_mem[a] : '0;
    m_rets.push_back(r);
  endtask

  // One cycle: drive at the rising edge, check 1ns later, advance the model, wait for the next rising edge
  task automatic applyStimulus(input logic dr, input logic [AW-1:0] da, input logic hr, input logic hw,
                               input logic [AW-1:0] ha, input logic [DW-1:0] hd,
                               input logic cs, input logic [DW-1:0] cv);
    int winner;
    bit exp_dv, exp_hv, was_clearing;
    ret_t r;
    disp_req = dr; disp_addr = da; host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
    clr_start = cs; clr_value = cv;
    #1;
    last_dgnt = disp_gnt; last_hgnt = host_gnt; last_busy = clr_busy; last_done = clr_done;
    last_drv = disp_rvalid; last_drd = disp_rdata; last_hrv = host_rvalid; last_hrd = host_rdata;

    exp_dv = 0; exp_hv = 0;
    if (m_rets.size() > 0 && m_rets[0].due == cyc) begin
      r = m_rets.pop_front();
      if (r.is_host) begin exp_hv = 1; m_host_last = r.data; end
      else begin exp_dv = 1; m_disp_last = r.data; end
    end
    checkOutput("disp_rvalid", 32'(disp_rvalid), 32'(exp_dv));
    checkOutput("disp_rdata", 32'(disp_rdata), 32'(m_disp_last));
    checkOutput("host_rvalid", 32'(host_rvalid), 32'(exp_hv));
    checkOutput("host_rdata", 32'(host_rdata), 32'(m_host_last));
    checkOutput("clr_busy", 32'(clr_busy), 32'(m_clearing));
    checkOutput("clr_done", 32'(clr_done), 32'(m_done_due));
    checkOutput("mem_en", 32'(mem_en), 32'(m_exp_en));
    checkOutput("mem_we", 32'(mem_we), 32'(m_exp_we));
    checkOutput("mem_addr", 32'(mem_addr), 32'(m_exp_addr));
    checkOutput("mem_wdata", 32'(mem_wdata), 32'(m_exp_wdata));

    // winner: 0 none, 1 host, 2 display, 3 clear
    if (hr && m_wait == HMW) winner = 1;
    else if (dr)             winner = 2;
    else if (m_clearing)     winner = 3;
    else if (hr)             winner = 1;
    else                     winner = 0;
    checkOutput("disp_gnt", 32'(disp_gnt), 32'(winner == 2));
    checkOutput("host_gnt", 32'(host_gnt), 32'(winner == 1));

    was_clearing = m_clearing;
    m_exp_en = 0; m_exp_we = 0; m_done_due = 0;
    if (winner == 1) begin
      if (in_range(ha)) begin
        m_exp_en = 1; m_exp_addr = int'(ha);
        if (hw) begin m_exp_we = 1; m_exp_wdata = hd; m_mem[ha] = hd; end
      end
      if (!hw) pushRead(1'b1, ha);
    end else if (winner == 2) begin
      if (in_range(da)) begin m_exp_en = 1; m_exp_addr = int'(da); end
      pushRead(1'b0, da);
    end else if (winner == 3) begin
      m_exp_en = 1; m_exp_we = 1; m_exp_addr = m_ptr; m_exp_wdata = m_cval;
      m_mem[m_ptr] = m_cval;
      if (m_ptr == DEPTH - 1) begin m_ptr = 0; m_clearing = 0; m_done_due = 1; end
      else m_ptr++;
    end
    if (hr && winner != 1) m_wait = (m_wait < HMW) ? m_wait + 1 : HMW;
    else                   m_wait = 0;
    if (!was_clearing && cs) begin m_clearing = 1; m_ptr = 0; m_cval = cv; end
    cyc++;
    @(posedge clk);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, '0, 0, 0, '0, '0, 0, '0);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int r = int'($urandom_range(15, 0));
`ifdef FB_ADDR_CHECK_EN
    if (r == 15) return AW'($urandom_range(8191, DEPTH));
`endif
    if (r < 4) return AW'($urandom_range(15, 0));
    if (r < 8) return AW'(DEPTH - 1 - int'($urandom_range(15, 0)));
    return AW'($urandom_range(DEPTH - 1, 0));
  endfunction

  initial begin
    int busy_cnt, done_cnt, gnt_cyc, d_hits, h_hits;
    bit seen, h_pend, h_we;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_data, seen_data;

    for (int i = 0; i < 8192; i++) begin ram[i] = '0; m_mem[i] = '0; end
    for (int i = 0; i < LAT; i++) ram_pipe[i] = '0;
    modelReset();

    @(posedge clk); #1;
    checkOutput("rst_mem_en", 32'(mem_en), 32'(0));
    checkOutput("rst_clr_busy", 32'(clr_busy), 32'(0));
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'(0));
    @(posedge clk);
    rst = 1'b1;

    $display("[TB] reset during clear");
    applyStimulus(0, '0, 0, 0, '0, '0, 1, 8'h55);
    idleCycles(100);
    checkOutput("preclr_ptr_busy", 32'(clr_busy), 32'(1));
    #2 rst = 1'b0;
    #1;
    checkOutput("mid_rst_busy", 32'(clr_busy), 32'(0));
    checkOutput("mid_rst_done", 32'(clr_done), 32'(0));
    checkOutput("mid_rst_mem_en", 32'(mem_en), 32'(0));
    checkOutput("mid_rst_mem_we", 32'(mem_we), 32'(0));
    checkOutput("mid_rst_mem_addr", 32'(mem_addr), 32'(0));
    checkOutput("mid_rst_mem_wdata", 32'(mem_wdata), 32'(0));
    checkOutput("mid_rst_rvalids", 32'({disp_rvalid, host_rvalid}), 32'(0));
    checkOutput("mid_rst_rdatas", 32'({disp_rdata, host_rdata}), 32'(0));
    checkOutput("mid_rst_gnts", 32'({disp_gnt, host_gnt}), 32'(0));
    @(posedge clk); @(posedge clk);
    rst = 1'b1;
    modelReset();
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, '0, 0, 0, '0, '0, 0, '0);
      if (last_done) done_cnt++;
    end
    checkOutput("no_done_after_rst", 32'(done_cnt), 32'(0));

    $display("[TB] full clear");
    applyStimulus(0, '0, 0, 0, '0, '0, 1, 8'h20);
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < DEPTH + 10; i++) begin
      applyStimulus(0, '0, 0, 0, '0, '0, 0, '0);
      if (last_busy) busy_cnt++;
      if (last_done) done_cnt++;
    end
    checkOutput("clr_busy_cycles", 32'(busy_cnt), 32'(DEPTH));
    checkOutput("clr_done_pulses", 32'(done_cnt), 32'(1));
    applyStimulus(0, '0, 1, 0, 13'h0000, '0, 0, '0);
    seen = 0; seen_data = '0;
    for (int i = 0; i < LAT + 3; i++) begin
      applyStimulus(0, '0, 0, 0, '0, '0, 0, '0);
      if (last_hrv && !seen) begin seen = 1; seen_data = last_hrd; end
    end
    checkOutput("post_clr_rd_seen", 32'(seen), 32'(1));
    checkOutput("post_clr_rd_data", 32'(seen_data), 32'(8'h20));

    $display("[TB] display beats host");
    applyStimulus(1, 13'h0005, 1, 0, 13'h0010, '0, 0, '0);
    checkOutput("contend_disp_gnt", 32'(last_dgnt), 32'(1));
    checkOutput("contend_host_gnt", 32'(last_hgnt), 32'(0));
    applyStimulus(0, '0, 1, 0, 13'h0010, '0, 0, '0);
    checkOutput("host_first_free", 32'(last_hgnt), 32'(1));
    idleCycles(LAT + 2);

    $display("[TB] host starvation");
    gnt_cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1, AW'(i), (gnt_cyc < 0), 1, 13'h12BF, 8'h41, 0, '0);
      if (last_hgnt && gnt_cyc < 0) begin
        gnt_cyc = i;
        checkOutput("starve_mem_we", 32'(mem_we), 32'(1));
        checkOutput("starve_mem_addr", 32'(mem_addr), 32'(13'h12BF));
        checkOutput("starve_mem_wdata", 32'(mem_wdata), 32'(8'h41));
      end
    end
    checkOutput("starve_gnt_cycle", 32'(gnt_cyc), 32'(9));
    idleCycles(LAT + 2);
    applyStimulus(0, '0, 1, 0, 13'h12BF, '0, 0, '0);
    idleCycles(LAT + 2);

    $display("[TB] alternating reads");
    applyStimulus(0, '0, 1, 1, 13'h0001, 8'hA1, 0, '0);
    applyStimulus(0, '0, 1, 1, 13'h0002, 8'hB2, 0, '0);
    idleCycles(2);
    d_hits = 0; h_hits = 0;
    for (int i = 0; i < 8 + LAT + 3; i++) begin
      if (i < 8) applyStimulus((i % 2) == 0, 13'h0001, (i % 2) == 1, 0, 13'h0002, '0, 0, '0);
      else       applyStimulus(0, '0, 0, 0, '0, '0, 0, '0);
      if (last_drv && last_drd == 8'hA1) d_hits++;
      if (last_hrv && last_hrd == 8'hB2) h_hits++;
    end
    checkOutput("alt_disp_returns", 32'(d_hits), 32'(4));
    checkOutput("alt_host_returns", 32'(h_hits), 32'(4));

`ifdef FB_ADDR_CHECK_EN
    $display("[TB] out-of-range host accesses");
    applyStimulus(0, '0, 1, 1, 13'h12C0, 8'h77, 0, '0);
    checkOutput("oor_wr_gnt", 32'(last_hgnt), 32'(1));
    checkOutput("oor_wr_mem_en", 32'(mem_en), 32'(0));
    applyStimulus(0, '0, 1, 0, 13'h1FFF, '0, 0, '0);
    checkOutput("oor_rd_gnt", 32'(last_hgnt), 32'(1));
    seen = 0; seen_data = 8'hFF;
    for (int i = 0; i < LAT + 3; i++) begin
      applyStimulus(0, '0, 0, 0, '0, '0, 0, '0);
      if (last_hrv && !seen) begin seen = 1; seen_data = last_hrd; end
    end
    checkOutput("oor_rd_seen", 32'(seen), 32'(1));
    checkOutput("oor_rd_data", 32'(seen_data), 32'(0));
`endif

    $display("[TB] random traffic");
    h_pend = 0; h_we = 0; h_addr = '0; h_data = '0;
    for (int i = 0; i < 4000 || m_clearing; i++) begin
      if (!h_pend && $urandom_range(9, 0) < 4) begin
        h_pend = 1; h_we = 1'($urandom_range(1, 0)); h_addr = rand_addr(); h_data = DW'($urandom);
      end
      applyStimulus(1'($urandom_range(1, 0)), rand_addr(), h_pend, h_we, h_addr, h_data,
                    $urandom_range(1999, 0) == 0, DW'($urandom));
      if (last_hgnt) h_pend = 0;
      if (i > 30000) begin
        checkOutput("random_phase_bound", 32'(0), 32'(1));
        break;
      end
    end
    idleCycles(LAT + 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
